// File: rtl/fetch_pc_unit.sv
// Instruction-fetch front end: owns the PC, drives the synchronous instruction
// memory and hands instructions to decode over valid/ready. A one-entry skid
// buffer absorbs the one-cycle memory read latency under backpressure.
module fetch_pc_unit #(
  parameter int unsigned    PC_W     = 8,
  parameter int unsigned    INSTR_W  = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_en,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [INSTR_W-1:0] if_instr,
  output logic [PC_W-1:0]    if_pc,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  input  logic               halt_req,
  output logic               halted
);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic                 halted_q, halted_d;
  logic [PC_W-1:0]      pc_q, pc_d;
  logic                 inflight_q, inflight_d;
  logic [PC_W-1:0]      tag_q, tag_d;
  logic                 out_valid_q, out_valid_d;
  logic [INSTR_W-1:0]   out_instr_q, out_instr_d;
  logic [PC_W-1:0]      out_pc_q, out_pc_d;
  logic                 skid_valid_q, skid_valid_d;
  logic [INSTR_W-1:0]   skid_instr_q, skid_instr_d;
  logic [PC_W-1:0]      skid_pc_q, skid_pc_d;

  logic xfer;
  logic out_free;

  assign xfer     = out_valid_q & if_ready;
  assign out_free = ~out_valid_q | xfer;

  // Issue only when the returning word is guaranteed a slot (output or skid).
  assign imem_en = (state_q == ST_RUN) & ~redirect_valid & ~skid_valid_q
                 & ~(out_valid_q & ~if_ready & inflight_q);

  assign imem_addr = pc_q;
  assign if_valid  = out_valid_q;
  assign if_instr  = out_instr_q;
  assign if_pc     = out_pc_q;
  assign halted    = halted_q;

  // Next-state: return path, issue, FSM, then redirect overrides everything.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    inflight_d   = 1'b0;
    tag_d        = tag_q;
    out_valid_d  = out_valid_q;
    out_instr_d  = out_instr_q;
    out_pc_d     = out_pc_q;
    skid_valid_d = skid_valid_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;

    // Skid drains ahead of new return data to keep program order.
    if (out_free) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_instr_d  = skid_instr_q;
        out_pc_d     = skid_pc_q;
        skid_valid_d = inflight_q;
        if (inflight_q) begin
          skid_instr_d = imem_rdata;
          skid_pc_d    = tag_q;
        end
      end else if (inflight_q) begin
        out_valid_d = 1'b1;
        out_instr_d = imem_rdata;
        out_pc_d    = tag_q;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (inflight_q) begin
      skid_valid_d = 1'b1;
      skid_instr_d = imem_rdata;
      skid_pc_d    = tag_q;
    end

    if (imem_en) begin
      pc_d       = pc_q + PC_W'(1);
      inflight_d = 1'b1;
      tag_d      = pc_q;
    end

    if ((state_q == ST_RUN) && halt_req && !redirect_valid) begin
      state_d = ST_HALT;
    end

    // Redirect squashes everything in flight or buffered and restarts fetch.
    if (redirect_valid) begin
      state_d      = ST_RUN;
      pc_d         = redirect_pc;
      inflight_d   = 1'b0;
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end

    halted_d = (state_d == ST_HALT);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_RUN;
      halted_q     <= 1'b0;
      pc_q         <= RESET_PC;
      inflight_q   <= 1'b0;
      tag_q        <= '0;
      out_valid_q  <= 1'b0;
      out_instr_q  <= '0;
      out_pc_q     <= '0;
      skid_valid_q <= 1'b0;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      halted_q     <= halted_d;
      pc_q         <= pc_d;
      inflight_q   <= inflight_d;
      tag_q        <= tag_d;
      out_valid_q  <= out_valid_d;
      out_instr_q  <= out_instr_d;
      out_pc_q     <= out_pc_d;
      skid_valid_q <= skid_valid_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
    end
  end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: two instances share stimulus, one with
// RESET_PC=0 and one with RESET_PC=0xFE for the wrap-around case.
module tb_fetch_pc_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_ready;
  logic        redirect_valid;
  logic [7:0]  redirect_pc;
  logic        halt_req;

  logic        imem_en, if_valid, halted;
  logic [7:0]  imem_addr, if_pc;
  logic [31:0] imem_rdata, if_instr;

  logic        imem_en_b, if_valid_b, halted_b;
  logic [7:0]  imem_addr_b, if_pc_b;
  logic [31:0] imem_rdata_b, if_instr_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [7:0] a);
    return {a, ~a, 8'h5A, a};
  endfunction

  // Synchronous instruction memories, one per instance.
  always @(posedge clk) begin
    if (imem_en)   imem_rdata   <= instr_of(imem_addr);
    if (imem_en_b) imem_rdata_b <= instr_of(imem_addr_b);
  end

  fetch_pc_unit #(.PC_W(8), .INSTR_W(32), .RESET_PC(8'h00)) u_dut (
    .clk(clk), .rst(rst), .imem_en(imem_en), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .if_valid(if_valid), .if_ready(if_ready),
    .if_instr(if_instr), .if_pc(if_pc), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .halt_req(halt_req), .halted(halted)
  );

  fetch_pc_unit #(.PC_W(8), .INSTR_W(32), .RESET_PC(8'hFE)) u_dut_fe (
    .clk(clk), .rst(rst), .imem_en(imem_en_b), .imem_addr(imem_addr_b),
    .imem_rdata(imem_rdata_b), .if_valid(if_valid_b), .if_ready(if_ready),
    .if_instr(if_instr_b), .if_pc(if_pc_b), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .halt_req(halt_req), .halted(halted_b)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; if_ready = 1'b1; redirect_valid = 1'b0;
    redirect_pc = 8'h00; halt_req = 1'b0;
    cyc(); cyc();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; if_ready = 1'b0; redirect_valid = 1'b0;
    redirect_pc = 8'h00; halt_req = 1'b0;
    cyc(); cyc();
    n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", if_valid); end
    n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted got %b exp 0", halted); end
    n_checks++; if (imem_addr !== 8'h00) begin n_fail++; $display("FAIL reset_pc got %h exp 00", imem_addr); end
    n_checks++; if (if_pc !== 8'h00) begin n_fail++; $display("FAIL reset_if_pc got %h exp 00", if_pc); end
    n_checks++; if (if_instr !== 32'h0) begin n_fail++; $display("FAIL reset_if_instr got %h exp 0", if_instr); end
    n_checks++; if (imem_addr_b !== 8'hFE) begin n_fail++; $display("FAIL reset_pc_fe got %h exp fe", imem_addr_b); end
  endtask

  task automatic test_stream();
    do_reset();
    for (int c = 0; c < 6; c++) begin
      if (c <= 4) begin
        n_checks++; if (imem_en !== 1'b1) begin n_fail++; $display("FAIL stream_en c=%0d got %b exp 1", c, imem_en); end
        n_checks++; if (imem_addr !== 8'(c)) begin n_fail++; $display("FAIL stream_addr c=%0d got %h exp %h", c, imem_addr, 8'(c)); end
      end
      if (c < 2) begin
        n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL stream_early_valid c=%0d got %b exp 0", c, if_valid); end
      end else begin
        n_checks++;
        if (if_valid !== 1'b1 || if_pc !== 8'(c - 2) || if_instr !== instr_of(8'(c - 2))) begin
          n_fail++;
          $display("FAIL stream_out c=%0d got v=%b pc=%h i=%h exp v=1 pc=%h i=%h",
                   c, if_valid, if_pc, if_instr, 8'(c - 2), instr_of(8'(c - 2)));
        end
      end
      cyc();
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp;
    do_reset();
    repeat (5) cyc();
    n_checks++; if (if_valid !== 1'b1 || if_pc !== 8'h03) begin n_fail++; $display("FAIL bp_pre got v=%b pc=%h exp v=1 pc=03", if_valid, if_pc); end
    if_ready = 1'b0;
    #1;
    n_checks++; if (imem_en !== 1'b0) begin n_fail++; $display("FAIL bp_en_stall0 got %b exp 0", imem_en); end
    for (int k = 0; k < 2; k++) begin
      cyc();
      n_checks++; if (imem_en !== 1'b0) begin n_fail++; $display("FAIL bp_en_stall k=%0d got %b exp 0", k, imem_en); end
      n_checks++; if (if_valid !== 1'b1 || if_pc !== 8'h03) begin n_fail++; $display("FAIL bp_hold k=%0d got v=%b pc=%h exp v=1 pc=03", k, if_valid, if_pc); end
      n_checks++; if (imem_addr !== 8'h05) begin n_fail++; $display("FAIL bp_pc_hold k=%0d got %h exp 05", k, imem_addr); end
    end
    cyc();
    if_ready = 1'b1;
    #1;
    n_checks++; if (imem_en !== 1'b0) begin n_fail++; $display("FAIL bp_en_skidfull got %b exp 0", imem_en); end
    exp = 8'h03;
    for (int k = 0; k < 8; k++) begin
      if (if_valid && if_ready) begin
        n_checks++;
        if (if_pc !== exp || if_instr !== instr_of(exp)) begin
          n_fail++; $display("FAIL bp_order got pc=%h i=%h exp pc=%h i=%h", if_pc, if_instr, exp, instr_of(exp));
        end
        exp = exp + 8'd1;
      end
      cyc();
    end
    n_checks++; if (exp !== 8'h0A) begin n_fail++; $display("FAIL bp_count got next=%h exp 0a", exp); end
  endtask

  task automatic test_redirect();
    logic [7:0] exp;
    do_reset();
    repeat (10) cyc();
    n_checks++; if (if_valid !== 1'b1 || if_pc !== 8'h08) begin n_fail++; $display("FAIL rd_pre got v=%b pc=%h exp v=1 pc=08", if_valid, if_pc); end
    n_checks++; if (imem_addr !== 8'h0A) begin n_fail++; $display("FAIL rd_pre_pc got %h exp 0a", imem_addr); end
    if_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 8'h40;
    #1;
    n_checks++; if (imem_en !== 1'b0) begin n_fail++; $display("FAIL rd_no_issue got %b exp 0", imem_en); end
    cyc();
    redirect_valid = 1'b0; if_ready = 1'b1;
    #1;
    n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL rd_flush got %b exp 0", if_valid); end
    n_checks++; if (imem_addr !== 8'h40 || imem_en !== 1'b1) begin n_fail++; $display("FAIL rd_target got addr=%h en=%b exp addr=40 en=1", imem_addr, imem_en); end
    exp = 8'h40;
    for (int k = 0; k < 6; k++) begin
      if (if_valid && if_ready) begin
        n_checks++;
        if (if_pc !== exp || if_instr !== instr_of(exp)) begin
          n_fail++; $display("FAIL rd_order got pc=%h i=%h exp pc=%h i=%h", if_pc, if_instr, exp, instr_of(exp));
        end
        exp = exp + 8'd1;
      end
      cyc();
    end
    n_checks++; if (exp !== 8'h44) begin n_fail++; $display("FAIL rd_count got next=%h exp 44", exp); end
    // Redirect and halt together: redirect wins.
    halt_req = 1'b1; redirect_valid = 1'b1; redirect_pc = 8'h20;
    #1;
    n_checks++; if (imem_en !== 1'b0) begin n_fail++; $display("FAIL rdh_no_issue got %b exp 0", imem_en); end
    cyc();
    halt_req = 1'b0; redirect_valid = 1'b0;
    #1;
    n_checks++; if (halted !== 1'b0 || imem_addr !== 8'h20 || if_valid !== 1'b0) begin
      n_fail++; $display("FAIL rdh_result got h=%b addr=%h v=%b exp h=0 addr=20 v=0", halted, imem_addr, if_valid);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] exp;
    do_reset();
    exp = 8'hFE;
    for (int k = 0; k < 8; k++) begin
      if (k == 2) begin
        n_checks++; if (imem_addr_b !== 8'h00) begin n_fail++; $display("FAIL wrap_pc got %h exp 00", imem_addr_b); end
      end
      if (if_valid_b && if_ready) begin
        n_checks++;
        if (if_pc_b !== exp || if_instr_b !== instr_of(exp)) begin
          n_fail++; $display("FAIL wrap_order got pc=%h i=%h exp pc=%h i=%h", if_pc_b, if_instr_b, exp, instr_of(exp));
        end
        exp = exp + 8'd1;
      end
      cyc();
    end
    n_checks++; if (exp !== 8'h04) begin n_fail++; $display("FAIL wrap_count got next=%h exp 04", exp); end
  endtask

  task automatic test_halt();
    logic [7:0] exp;
    do_reset();
    cyc(); cyc();
    halt_req = 1'b1;
    #1;
    n_checks++; if (imem_en !== 1'b1 || imem_addr !== 8'h02) begin n_fail++; $display("FAIL halt_last_issue got en=%b addr=%h exp en=1 addr=02", imem_en, imem_addr); end
    n_checks++; if (if_valid !== 1'b1 || if_pc !== 8'h00) begin n_fail++; $display("FAIL halt_first got v=%b pc=%h exp v=1 pc=00", if_valid, if_pc); end
    exp = 8'h01;
    cyc();
    halt_req = 1'b0;
    #1;
    n_checks++; if (halted !== 1'b1 || imem_en !== 1'b0 || imem_addr !== 8'h03) begin
      n_fail++; $display("FAIL halt_enter got h=%b en=%b addr=%h exp h=1 en=0 addr=03", halted, imem_en, imem_addr);
    end
    for (int k = 0; k < 5; k++) begin
      if (if_valid && if_ready) begin
        n_checks++;
        if (if_pc !== exp || if_instr !== instr_of(exp)) begin
          n_fail++; $display("FAIL halt_drain got pc=%h i=%h exp pc=%h i=%h", if_pc, if_instr, exp, instr_of(exp));
        end
        exp = exp + 8'd1;
      end
      halt_req = (k == 2);
      cyc();
    end
    halt_req = 1'b0;
    #1;
    n_checks++; if (exp !== 8'h03 || if_valid !== 1'b0) begin n_fail++; $display("FAIL halt_drained got next=%h v=%b exp next=03 v=0", exp, if_valid); end
    n_checks++; if (halted !== 1'b1 || imem_en !== 1'b0 || imem_addr !== 8'h03) begin
      n_fail++; $display("FAIL halt_hold got h=%b en=%b addr=%h exp h=1 en=0 addr=03", halted, imem_en, imem_addr);
    end
    redirect_valid = 1'b1; redirect_pc = 8'h10;
    cyc();
    redirect_valid = 1'b0;
    #1;
    n_checks++; if (halted !== 1'b0 || imem_en !== 1'b1 || imem_addr !== 8'h10) begin
      n_fail++; $display("FAIL halt_resume got h=%b en=%b addr=%h exp h=0 en=1 addr=10", halted, imem_en, imem_addr);
    end
    exp = 8'h10;
    for (int k = 0; k < 5; k++) begin
      if (if_valid && if_ready) begin
        n_checks++;
        if (if_pc !== exp || if_instr !== instr_of(exp)) begin
          n_fail++; $display("FAIL halt_resume_order got pc=%h i=%h exp pc=%h i=%h", if_pc, if_instr, exp, instr_of(exp));
        end
        exp = exp + 8'd1;
      end
      cyc();
    end
    n_checks++; if (exp !== 8'h13) begin n_fail++; $display("FAIL halt_resume_count got next=%h exp 13", exp); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp;
    do_reset();
    repeat (5) cyc();
    if_ready = 1'b0;
    cyc();
    n_checks++; if (imem_en !== 1'b0 || if_valid !== 1'b1) begin n_fail++; $display("FAIL rm_pre got en=%b v=%b exp en=0 v=1", imem_en, if_valid); end
    rst = 1'b1;
    cyc();
    rst = 1'b0; if_ready = 1'b1;
    #1;
    n_checks++; if (if_valid !== 1'b0 || halted !== 1'b0) begin n_fail++; $display("FAIL rm_clear got v=%b h=%b exp v=0 h=0", if_valid, halted); end
    n_checks++; if (imem_addr !== 8'h00 || imem_en !== 1'b1) begin n_fail++; $display("FAIL rm_pc got addr=%h en=%b exp addr=00 en=1", imem_addr, imem_en); end
    exp = 8'h00;
    for (int k = 0; k < 6; k++) begin
      if (if_valid && if_ready) begin
        n_checks++;
        if (if_pc !== exp || if_instr !== instr_of(exp)) begin
          n_fail++; $display("FAIL rm_order got pc=%h i=%h exp pc=%h i=%h", if_pc, if_instr, exp, instr_of(exp));
        end
        exp = exp + 8'd1;
      end
      cyc();
    end
    n_checks++; if (exp !== 8'h04) begin n_fail++; $display("FAIL rm_count got next=%h exp 04", exp); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_halt();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
